// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a single-cycle fast path for divide special cases.
module muldiv_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             Z,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = '1;

  state_t               r_state, w_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_op;
  logic [WIDTH-1:0]     r_a;      // |A| (multiplicand) or |B| (divisor)
  logic [2*WIDTH-1:0]   r_prod;   // mul: {hi, lo}; div: {remainder, quotient}
  logic                 r_neg_q, r_neg_r;
  logic [WIDTH-1:0]     r_out;
  logic                 r_z;

  // operand signedness from funct3
  logic             w_div, w_sa, w_sb, w_na, w_nb, w_div0, w_ovf, w_fast, w_accept;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_fres;

  assign w_div    = op[2];
  assign w_sa     = w_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign w_sb     = w_div ? ~op[0] : (op[1:0] == 2'b01);
  assign w_na     = w_sa & DATA_A[WIDTH-1];
  assign w_nb     = w_sb & DATA_B[WIDTH-1];
  assign w_abs_a  = w_na ? -DATA_A : DATA_A;
  assign w_abs_b  = w_nb ? -DATA_B : DATA_B;
  assign w_div0   = w_div & (DATA_B == '0);
  assign w_ovf    = w_div & ~op[0] & (DATA_A == MIN) & (DATA_B == ONES);
  assign w_fast   = w_div0 | w_ovf;
  assign w_fres   = w_div0 ? (op[1] ? DATA_A : ONES) : (op[1] ? '0 : MIN);
  assign w_accept = (r_state == IDLE) & in_valid & ~flush;

  // one iteration of either algorithm
  logic [WIDTH-1:0]   w_hi, w_lo, w_hi_d;
  logic [WIDTH:0]     w_sum, w_rt, w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_step;

  assign w_hi   = r_prod[2*WIDTH-1:WIDTH];
  assign w_lo   = r_prod[WIDTH-1:0];
  assign w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_a} : '0);
  assign w_rt   = {w_hi, w_lo[WIDTH-1]};
  assign w_diff = w_rt - {1'b0, r_a};
  assign w_ge   = ~w_diff[WIDTH];
  assign w_hi_d = w_ge ? w_diff[WIDTH-1:0] : w_rt[WIDTH-1:0];
  assign w_step = r_op[2] ? {w_hi_d, w_lo[WIDTH-2:0], w_ge}
                          : {w_sum, w_lo[WIDTH-1:1]};

  // sign correction and result selection
  logic [2*WIDTH-1:0] w_ps;
  logic [WIDTH-1:0]   w_q, w_r, w_res;

  assign w_ps  = r_neg_q ? -r_prod : r_prod;
  assign w_q   = r_neg_q ? -w_lo : w_lo;
  assign w_r   = r_neg_r ? -w_hi : w_hi;
  assign w_res = r_op[2] ? (r_op[1] ? w_r : w_q)
                         : ((r_op[1:0] == 2'b00) ? w_ps[WIDTH-1:0] : w_ps[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nxt = w_fast ? DONE : CALC;
      CALC: if (flush) w_nxt = IDLE;
            else if (r_cnt == CNT_W'(WIDTH-1)) w_nxt = FIX;
      FIX:  w_nxt = flush ? IDLE : DONE;
      DONE: if (flush || out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_prod  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_out   <= '0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= op;
          r_cnt   <= '0;
          r_neg_q <= w_na ^ w_nb;
          r_neg_r <= w_na;
          r_a     <= w_div ? w_abs_b : w_abs_a;
          r_prod  <= {{WIDTH{1'b0}}, (w_div ? w_abs_a : w_abs_b)};
          if (w_fast) begin
            r_out <= w_fres;
            r_z   <= (w_fres == '0);
          end
        end
        CALC: begin
          r_prod <= w_step;
          r_cnt  <= r_cnt + 1'b1;
        end
        FIX: if (!flush) begin
          r_out <= w_res;
          r_z   <= (w_res == '0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign OUT       = r_out;
  assign Z         = r_z;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq at WIDTH=32.
module tb_muldiv_seq;
  localparam int W = 32;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic         clk = 1'b0;
  logic         reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] DATA_A = '0, DATA_B = '0;
  logic         in_ready, out_valid, Z, busy;
  logic [W-1:0] OUT;
  int           checks = 0, fails = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .DATA_A(DATA_A), .DATA_B(DATA_B), .out_valid(out_valid),
    .out_ready(out_ready), .OUT(OUT), .Z(Z), .busy(busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // accept one op from IDLE, then scramble inputs to show they are not re-sampled
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; DATA_A = a; DATA_B = b; in_valid = 1'b1;
    step;
    in_valid = 1'b0; op = 3'($urandom); DATA_A = $urandom; DATA_B = $urandom;
  endtask

  // called right after the accepting edge; that edge counts as cycle 1
  task automatic wait_res(input string tag, input int lat, input logic [W-1:0] exp, input logic ez);
    int n = 1;
    while (!out_valid && n < 200) begin
      step;
      n++;
    end
    chk({tag, ".lat"}, W'(n), W'(lat));
    chk({tag, ".out"}, OUT, exp);
    chk({tag, ".z"}, W'(Z), W'(ez));
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    out_ready = 1'b1;
    issue(o, a, b);
    wait_res(tag, lat, exp, exp == '0);
    step;
    chk({tag, ".idle"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int seen;
    step; step;
    reset = 1'b0;
    chk("rst.in_ready", W'(in_ready), W'(1));
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.out", OUT, '0);
    chk("rst.z", W'(Z), W'(0));

    out_ready = 1'b1;
    issue(MUL, 32'd7, 32'hFFFF_FFFD);
    chk("mul.in_ready", W'(in_ready), W'(0));
    chk("mul.busy", W'(busy), W'(1));
    wait_res("mul", 34, 32'hFFFF_FFEB, 1'b0);
    step;

    run("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("mulz",   MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 34);
    run("mulh2",  MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 34);
    run("div",    DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run("rem",    REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run("div2",   DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run("rem2",   REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34);
    run("divu",   DIVU,   32'd100,       32'd7,         32'd14,        34);
    run("remu",   REMU,   32'd100,       32'd7,         32'd2,         34);
    run("divu0",  DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run("rem0",   REM,    32'd5,         32'd0,         32'd5,         1);
    run("divovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("removf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // backpressure in DONE with junk requests on the input side
    out_ready = 1'b0;
    issue(MUL, 32'd3, 32'd5);
    wait_res("bp", 34, 32'd15, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'(i); DATA_A = $urandom; DATA_B = $urandom;
      step;
      chk("bp.out", OUT, 32'd15);
      chk("bp.z", W'(Z), W'(0));
      chk("bp.in_ready", W'(in_ready), W'(0));
      chk("bp.out_valid", W'(out_valid), W'(1));
    end
    op = DIVU; DATA_A = 32'd100; DATA_B = 32'd7; out_ready = 1'b1;
    step;
    chk("bp.rel_in_ready", W'(in_ready), W'(1));
    chk("bp.rel_out_valid", W'(out_valid), W'(0));
    step;
    chk("bp.acc_in_ready", W'(in_ready), W'(0));
    in_valid = 1'b0;
    wait_res("bp2", 34, 32'd14, 1'b0);
    step;

    // flush mid-calculation
    issue(MUL, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 9; i++) step;
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("fl.busy", W'(busy), W'(0));
    chk("fl.in_ready", W'(in_ready), W'(1));
    chk("fl.out", OUT, 32'd14);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step;
    end
    chk("fl.no_valid", W'(seen), W'(0));
    run("fl.next", DIVU, 32'd100, 32'd7, 32'd14, 34);

    // flush in IDLE suppresses the accept
    flush = 1'b1; in_valid = 1'b1; op = DIVU; DATA_A = 32'd9; DATA_B = 32'd0;
    step;
    flush = 1'b0; in_valid = 1'b0;
    chk("fli.busy", W'(busy), W'(0));
    chk("fli.out_valid", W'(out_valid), W'(0));

    // reset while holding a result
    out_ready = 1'b0;
    issue(DIVU, 32'd5, 32'd0);
    chk("rd.out_valid", W'(out_valid), W'(1));
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("rd.out_valid0", W'(out_valid), W'(0));
    chk("rd.in_ready", W'(in_ready), W'(1));
    chk("rd.busy", W'(busy), W'(0));
    chk("rd.out", OUT, '0);
    chk("rd.z", W'(Z), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multi-cycle multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in operand width. It sits beside the single-cycle combinational ALU in the execute stage. The core stalls on in_ready/out_valid while an operation is in flight. It accepts one operation per valid/ready handshake and produces one registered result per handshake, with a zero flag matching the ALU's Z semantics.

Parameters:
WIDTH, 32, operand and result width in bits (even, >= 4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
flush  input  1  synchronous abort of the in-flight or held operation
in_valid  input  1  operation request
in_ready  output  1  unit can accept (high only in IDLE)
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
DATA_A  input  WIDTH  rs1 operand / dividend
DATA_B  input  WIDTH  rs2 operand / divisor
out_valid  output  1  result available
out_ready  input  1  consumer takes result
OUT  output  WIDTH  result, registered
Z  output  1  1 when OUT == 0, registered with OUT
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, OUT=0, Z=0, counter=0. reset has priority over flush and over every handshake.
- States:
  - IDLE: in_ready=1. On in_valid, register op and operands, take absolute values per the op's signedness, and record result-sign bits.
  - Divide fast path: if op is a divide or remainder and DATA_B==0, or op=DIV/REM with DATA_A=min-signed and DATA_B=all-ones, go directly to DONE with the special result. Otherwise go to CALC with counter=0.
  - CALC: exactly WIDTH cycles, one bit per cycle.
    - Multiply: shift-add into a 2*WIDTH-bit product register.
    - Divide: restoring shift-subtract producing a WIDTH-bit quotient and remainder.
    - When counter reaches WIDTH-1, go to FIX.
  - FIX: one cycle. Apply two's-complement sign correction, select the low half (MUL), high half (MULH/MULHSU/MULHU), quotient or remainder, load OUT, compute Z, and go to DONE.
  - DONE: out_valid=1. OUT and Z are held stable while out_ready=0. On out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: out_valid is first high WIDTH+2 cycles after the accepting edge (34 for WIDTH=32). The fast path takes 1 cycle. There is no bypass from DONE to the next accept; minimum issue interval is latency+1 cycles.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Quotient sign = signA XOR signB. Remainder sign = sign of dividend.
- Special results:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return DATA_A.
  - Signed overflow: DIV returns min-signed; REM returns 0.
- Other opcodes: op is fully decoded, so there is no illegal op.
- Operand stability: DATA_A, DATA_B and op are sampled only at the accepting edge. Later input changes have no effect.
- flush: returns to IDLE on the next edge from CALC, FIX or DONE. out_valid=0 next cycle. OUT retains its last value and no result is delivered. flush in IDLE with in_valid high suppresses the accept.
- Simultaneous events: reset beats flush; flush beats out_ready; in_valid is ignored outside IDLE.

Test Plan:
- Reset then MUL A=7, B=0xFFFFFFFD, out_ready=1 -> in_ready drops, out_valid exactly 34 cycles later, OUT=0xFFFFFFEB, Z=0.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL 0x10000*0x10000 -> 0x00000000 with Z=1.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast path: DIVU 5/0 -> 0xFFFFFFFF after 1 cycle; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0, Z=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle inputs with in_valid=1 -> OUT and Z stable, in_ready=0, no second accept; a new op is accepted on the cycle after out_ready returns the unit to IDLE.
- Abort: flush at CALC cycle 10 -> IDLE next cycle, out_valid never rises, next op correct. reset asserted in DONE -> all outputs return to reset values next cycle.
